// File: rtl/opf_pkg.sv
// Shared definitions for the operand fetch controller: mode encodings,
// instruction field positions and the FSM state type.
package opf_pkg;

   localparam logic [1:0] MODE_REG = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_IMM = 2'b10;
   localparam logic [1:0] MODE_ILL = 2'b11;

   localparam int INSTR_W  = 24;
   localparam int OPC_MSB  = 23;
   localparam int OPC_LSB  = 18;
   localparam int MODE_MSB = 17;
   localparam int MODE_LSB = 16;
   localparam int RS1_MSB  = 15;
   localparam int RS1_LSB  = 12;
   localparam int RS2_MSB  = 11;
   localparam int RS2_LSB  = 8;
   localparam int IMM_MSB  = 11;
   localparam int IMM_LSB  = 0;
   localparam int IMM_W    = 12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_MEM_REQ,
      S_MEM_WAIT,
      S_OUT
   } state_t;

endpackage

// File: rtl/operand_fetch_ctrl_if.sv
// Bundle of the instruction, register-file, memory and execute-side signals
// of the operand fetch controller. The controller uses the slave modport.
interface operand_fetch_ctrl_if #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned REG_ID_W = 4,
   parameter int unsigned ADDR_W   = 16
);
   logic                in_valid;
   logic                in_ready;
   logic [23:0]         instruction;
   logic                rf_rd_en1;
   logic                rf_rd_en2;
   logic [REG_ID_W-1:0] rf_id1;
   logic [REG_ID_W-1:0] rf_id2;
   logic [DATA_W-1:0]   rf_data1;
   logic [DATA_W-1:0]   rf_data2;
   logic                mem_req;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_gnt;
   logic                mem_rvalid;
   logic [DATA_W-1:0]   mem_rdata;
   logic                out_valid;
   logic                out_ready;
   logic [5:0]          opcode;
   logic [1:0]          mode;
   logic [DATA_W-1:0]   op1;
   logic [DATA_W-1:0]   op2;
   logic                err;

   modport slave (
      input  in_valid, instruction, rf_data1, rf_data2,
             mem_gnt, mem_rvalid, mem_rdata, out_ready,
      output in_ready, rf_rd_en1, rf_rd_en2, rf_id1, rf_id2,
             mem_req, mem_addr, out_valid, opcode, mode, op1, op2, err
   );

   modport master (
      output in_valid, instruction, rf_data1, rf_data2,
             mem_gnt, mem_rvalid, mem_rdata, out_ready,
      input  in_ready, rf_rd_en1, rf_rd_en2, rf_id1, rf_id2,
             mem_req, mem_addr, out_valid, opcode, mode, op1, op2, err
   );

endinterface

// File: rtl/opf_timeout_ctr.sv
// Saturating memory-wait counter. hit flags the enabled cycle in which the
// count reaches MEM_TIMEOUT, so the waiter can leave on that same edge.
module opf_timeout_ctr #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

   logic [7:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LIMIT)) begin
         count <= count + 8'd1;
      end
   end

   assign hit = en && (count >= (LIMIT - 8'd1));

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Decode-stage operand fetch sequencer. Define OPF_WB_FWD_EN to add the
// write-back forwarding ports (wb_en, wb_id, wb_data) used in CAP.
//
// state      | meaning
// S_IDLE     | waiting for an instruction, in_ready high
// S_RD       | register-file read enables asserted
// S_CAP      | register data captured, op2 chosen by mode
// S_MEM_REQ  | mem_req held until grant
// S_MEM_WAIT | waiting for mem_rvalid, timeout counter running
// S_OUT      | bundle valid, held until out_ready
module operand_fetch_ctrl
   import opf_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned REG_ID_W    = 4,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef OPF_WB_FWD_EN
   input  logic                wb_en,
   input  logic [REG_ID_W-1:0] wb_id,
   input  logic [DATA_W-1:0]   wb_data,
`endif
   operand_fetch_ctrl_if.slave bus
);

   state_t              state;
   logic [INSTR_W-1:0]  instr;
   logic [1:0]          mode_in;
   logic [1:0]          mode_q;
   logic [DATA_W-1:0]   data1_sel;
   logic [DATA_W-1:0]   data2_sel;
   logic [DATA_W-1:0]   imm_ext;
   logic [ADDR_W-1:0]   addr_ext;
   logic                tmo_clr;
   logic                tmo_en;
   logic                tmo_hit;

   logic                in_ready;
   logic                rf_rd_en1;
   logic                rf_rd_en2;
   logic [REG_ID_W-1:0] rf_id1;
   logic [REG_ID_W-1:0] rf_id2;
   logic                mem_req;
   logic [ADDR_W-1:0]   mem_addr;
   logic                out_valid;
   logic [5:0]          opcode;
   logic [1:0]          mode;
   logic [DATA_W-1:0]   op1;
   logic [DATA_W-1:0]   op2;
   logic                err;

   assign mode_in  = bus.instruction[MODE_MSB:MODE_LSB];
   assign mode_q   = instr[MODE_MSB:MODE_LSB];
   assign imm_ext  = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_MSB:IMM_LSB]};
   assign addr_ext = {{(ADDR_W-IMM_W){1'b0}}, instr[IMM_MSB:IMM_LSB]};

`ifdef OPF_WB_FWD_EN
   assign data1_sel = (wb_en && (wb_id == instr[RS1_MSB:RS1_LSB])) ? wb_data : bus.rf_data1;
   assign data2_sel = (wb_en && (wb_id == instr[RS2_MSB:RS2_LSB])) ? wb_data : bus.rf_data2;
`else
   assign data1_sel = bus.rf_data1;
   assign data2_sel = bus.rf_data2;
`endif

   // Counter is cleared for the whole grant wait and only runs while stalled.
   assign tmo_clr = (state == S_MEM_REQ);
   assign tmo_en  = (state == S_MEM_WAIT) && !bus.mem_rvalid;

   opf_timeout_ctr #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmo_clr),
      .en    (tmo_en),
      .hit   (tmo_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         instr     <= '0;
         in_ready  <= 1'b1;
         rf_rd_en1 <= 1'b0;
         rf_rd_en2 <= 1'b0;
         rf_id1    <= '0;
         rf_id2    <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         out_valid <= 1'b0;
         opcode    <= '0;
         mode      <= '0;
         op1       <= '0;
         op2       <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  instr    <= bus.instruction;
                  opcode   <= bus.instruction[OPC_MSB:OPC_LSB];
                  mode     <= mode_in;
                  err      <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= S_RD;
                  if (mode_in != MODE_ILL) begin
                     rf_rd_en1 <= 1'b1;
                     rf_id1    <= bus.instruction[RS1_MSB:RS1_LSB];
                  end
                  if (mode_in == MODE_REG) begin
                     rf_rd_en2 <= 1'b1;
                     rf_id2    <= bus.instruction[RS2_MSB:RS2_LSB];
                  end
               end
            end
            S_RD: begin
               rf_rd_en1 <= 1'b0;
               rf_rd_en2 <= 1'b0;
               if (mode_q == MODE_ILL) begin
                  op1       <= '0;
                  op2       <= '0;
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= S_OUT;
               end else begin
                  state <= S_CAP;
               end
            end
            S_CAP: begin
               op1 <= data1_sel;
               case (mode_q)
                  MODE_REG: begin
                     op2       <= data2_sel;
                     out_valid <= 1'b1;
                     state     <= S_OUT;
                  end
                  MODE_IMM: begin
                     op2       <= imm_ext;
                     out_valid <= 1'b1;
                     state     <= S_OUT;
                  end
                  default: begin
                     mem_req  <= 1'b1;
                     mem_addr <= addr_ext;
                     state    <= S_MEM_REQ;
                  end
               endcase
            end
            S_MEM_REQ: begin
               if (bus.mem_gnt) begin
                  mem_req <= 1'b0;
                  if (bus.mem_rvalid) begin
                     op2       <= bus.mem_rdata;
                     out_valid <= 1'b1;
                     state     <= S_OUT;
                  end else begin
                     state <= S_MEM_WAIT;
                  end
               end
            end
            S_MEM_WAIT: begin
               if (bus.mem_rvalid) begin
                  op2       <= bus.mem_rdata;
                  out_valid <= 1'b1;
                  state     <= S_OUT;
               end else if (tmo_hit) begin
                  op2       <= '0;
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= S_OUT;
               end
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.rf_rd_en1 = rf_rd_en1;
   assign bus.rf_rd_en2 = rf_rd_en2;
   assign bus.rf_id1    = rf_id1;
   assign bus.rf_id2    = rf_id2;
   assign bus.mem_req   = mem_req;
   assign bus.mem_addr  = mem_addr;
   assign bus.out_valid = out_valid;
   assign bus.opcode    = opcode;
   assign bus.mode      = mode;
   assign bus.op1       = op1;
   assign bus.op2       = op2;
   assign bus.err       = err;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Self-checking bench for operand_fetch_ctrl: directed cases plus random
// instructions checked against a latency/operand model of the fetch rules.
module tb_operand_fetch_ctrl;

   localparam int TMO = 15;

   logic clk;
   logic rst_n;

   operand_fetch_ctrl_if #(.DATA_W(16), .REG_ID_W(4), .ADDR_W(16)) bus ();

`ifdef OPF_WB_FWD_EN
   logic        wb_en;
   logic [3:0]  wb_id;
   logic [15:0] wb_data;
`endif

   operand_fetch_ctrl #(
      .DATA_W      (16),
      .REG_ID_W    (4),
      .ADDR_W      (16),
      .MEM_TIMEOUT (TMO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef OPF_WB_FWD_EN
      .wb_en   (wb_en),
      .wb_id   (wb_id),
      .wb_data (wb_data),
`endif
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] regfile [16];
   logic        en1_d, en2_d;
   logic [3:0]  id1_d, id2_d;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Register file model: data is valid only the cycle after a read enable.
   always @(posedge clk) begin
      en1_d = bus.rf_rd_en1;
      id1_d = bus.rf_id1;
      en2_d = bus.rf_rd_en2;
      id2_d = bus.rf_id2;
      #1;
      bus.rf_data1 = en1_d ? regfile[id1_d] : 16'($urandom);
      bus.rf_data2 = en2_d ? regfile[id2_d] : 16'($urandom);
   end

   task automatic randomize_rf();
      for (int i = 0; i < 16; i++) regfile[i] = 16'($urandom);
   endtask

   // g: extra cycles mem_req waits for grant; r: response cycles after grant
   // (0 = same cycle as grant, > TMO = never answers).
   task automatic run_txn(input logic [23:0] ins, input int g, input int r, input int stall);
      logic [1:0]  md;
      logic [15:0] rdat, e_op1, e_op2;
      logic        e_err, exp_req;
      int          e_lat, cyc;
      bit          bad_en, bad_req, bad_addr, bad_rdy, bad_stall;

      md       = ins[17:16];
      rdat     = 16'($urandom);
      e_err    = 1'b0;
      e_op1    = regfile[ins[15:12]];
      e_op2    = 16'h0;
      e_lat    = 0;
      case (md)
         2'b00: begin e_op2 = regfile[ins[11:8]]; e_lat = 2; end
         2'b10: begin e_op2 = {4'h0, ins[11:0]};  e_lat = 2; end
         2'b01: begin
            if (r <= TMO) begin e_op2 = rdat; e_lat = 3 + g + r; end
            else begin e_op2 = 16'h0; e_err = 1'b1; e_lat = 3 + g + TMO; end
         end
         default: begin e_op1 = 16'h0; e_op2 = 16'h0; e_err = 1'b1; e_lat = 1; end
      endcase

      check_val("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.in_valid    = 1'b1;
      bus.instruction = ins;
      @(posedge clk); #1;
      bus.in_valid    = 1'b0;
      bus.instruction = 24'($urandom);

      bad_en = 0; bad_req = 0; bad_addr = 0; bad_rdy = 0; bad_stall = 0;
      cyc = 0;
      while (1) begin
         if (cyc == 0) begin
            check_val("rd_en1", 32'(bus.rf_rd_en1), 32'(md != 2'b11));
            check_val("rd_en2", 32'(bus.rf_rd_en2), 32'(md == 2'b00));
            if (md != 2'b11) check_val("rf_id1", 32'(bus.rf_id1), 32'(ins[15:12]));
            if (md == 2'b00) check_val("rf_id2", 32'(bus.rf_id2), 32'(ins[11:8]));
         end else if (bus.rf_rd_en1 || bus.rf_rd_en2) begin
            bad_en = 1;
         end
         exp_req = (md == 2'b01) && (cyc >= 2) && (cyc <= 2 + g);
         if (bus.mem_req !== exp_req) bad_req = 1;
         if (bus.mem_req && (bus.mem_addr !== {4'h0, ins[11:0]})) bad_addr = 1;
         if (bus.in_ready !== 1'b0) bad_rdy = 1;
         bus.mem_gnt    = (md == 2'b01) && (cyc == 2 + g);
         bus.mem_rvalid = (md == 2'b01) && (r <= TMO) && (cyc == 2 + g + r);
         bus.mem_rdata  = bus.mem_rvalid ? rdat : 16'($urandom);
         if (bus.out_valid === 1'b1 || cyc >= 100) break;
         @(posedge clk); #1;
         cyc++;
      end
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;

      check_val("latency", 32'(cyc), 32'(e_lat));
      check_val("opcode", 32'(bus.opcode), 32'(ins[23:18]));
      check_val("mode", 32'(bus.mode), 32'(md));
      check_val("op1", 32'(bus.op1), 32'(e_op1));
      check_val("op2", 32'(bus.op2), 32'(e_op2));
      check_val("err", 32'(bus.err), 32'(e_err));
      check_val("rd_en_outside_rd", 32'(bad_en), 32'd0);
      check_val("mem_req_window", 32'(bad_req), 32'd0);
      check_val("mem_addr_stable", 32'(bad_addr), 32'd0);
      check_val("in_ready_busy", 32'(bad_rdy), 32'd0);

      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b1 || bus.op1 !== e_op1 || bus.op2 !== e_op2 ||
             bus.err !== e_err || bus.in_ready !== 1'b0) bad_stall = 1;
      end
      if (stall > 0) check_val("bundle_stable_stall", 32'(bad_stall), 32'd0);

      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check_val("out_valid_after_ready", 32'(bus.out_valid), 32'd0);
      check_val("in_ready_after_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      logic [23:0] ins;
      logic [1:0]  md;

      rst_n           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.instruction = '0;
      bus.rf_data1    = '0;
      bus.rf_data2    = '0;
      bus.mem_gnt     = 1'b0;
      bus.mem_rvalid  = 1'b0;
      bus.mem_rdata   = '0;
      bus.out_ready   = 1'b0;
`ifdef OPF_WB_FWD_EN
      wb_en   = 1'b0;
      wb_id   = '0;
      wb_data = '0;
`endif
      randomize_rf();

      repeat (2) @(posedge clk);
      #1;
      check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check_val("rst_rd_en", 32'({bus.rf_rd_en1, bus.rf_rd_en2}), 32'd0);
      check_val("rst_op", 32'({bus.op1, bus.op2}), 32'd0);
      check_val("rst_err", 32'(bus.err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases from the fetch rules
      regfile[3] = 16'h1111;
      regfile[5] = 16'h2222;
      run_txn(24'h043500, 0, 0, 0);
      run_txn(24'h063ABC, 0, 0, 0);
      run_txn(24'h053123, 3, 2, 0);
      run_txn(24'h053123, 0, 99, 0);
      run_txn(24'h073000, 0, 0, 5);
      run_txn(24'h053123, 1, 0, 0);
      run_txn(24'h053123, 0, TMO, 1);
      run_txn(24'h053123, 2, TMO + 1, 0);

      // Random instructions, grant/response delays and output stalls
      for (int t = 0; t < 40; t++) begin
         randomize_rf();
         ins = 24'($urandom);
         md  = ins[17:16];
         run_txn(ins, int'($urandom_range(0, 3)),
                 (md == 2'b01 && $urandom_range(0, 3) == 0) ? 99 : int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 3)));
      end

      // Reset during MEM_WAIT, then a stray late response
      bus.in_valid    = 1'b1;
      bus.instruction = 24'h053123;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.mem_gnt = 1'b1;
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_val("wait_no_out", 32'(bus.out_valid), 32'd0);
      check_val("wait_in_ready", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b0;
      #2;
      check_val("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
      check_val("async_rst_op1", 32'(bus.op1), 32'd0);
      check_val("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
      @(posedge clk); #1;
      rst_n          = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 16'hDEAD;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("late_rvalid_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("late_rvalid_op2", 32'(bus.op2), 32'd0);
      check_val("late_rvalid_in_ready", 32'(bus.in_ready), 32'd1);

      // Controller still works after the aborted fetch
      randomize_rf();
      run_txn(24'h043500, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
